title_loader: RTL and testbench
===============================

# title_loader

Byte-stream receiver that rebuilds the 16-bit title-screen image in memory. It accepts bytes one at a time over a valid/ready handshake and packs each pair into one word, low byte first. Each assembled word is written to sequential addresses from 0 to WORDS-1, then `finish` is raised. It is the receive-side counterpart of the title drawer: it loads the image RAM that the drawer later streams out, one byte per handshake.

## Interface

Parameters:
- WORDS, default 4096: number of 16-bit words to load, so the last address is WORDS-1.
- AW, default 16: width of the address output.

Ports:
- clock, input, 1: single system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low. Asserted when 0.
- datain, input, 8: incoming byte; must be stable while datavalid=1.
- datavalid, input, 1: producer holds it at 1 until it sees ready.
- ready, output, 1 (registered): one-cycle acknowledge that the byte has been captured.
- address, output, AW (registered): memory write address.
- dataout, output, 16 (registered): assembled word, {high byte, low byte}.
- writeenable, output, 1 (registered): one-cycle memory write strobe.
- finish, output, 1: 1 in DONE state, sticky until reset.

## Operation

- Reset values while reset=0:
  - ready=0, writeenable=0, finish=0.
  - address=0, dataout=0.
  - Internal low-byte register=0; state=LOW_WAIT.
- LOW_WAIT:
  - datavalid=1: capture datain into the low-byte register, go to LOW_ACK.
  - Otherwise stay.
- LOW_ACK: ready=1 for this cycle, then go to HIGH_WAIT.
- HIGH_WAIT:
  - datavalid=1: load dataout <= {datain, low-byte register}, go to HIGH_ACK.
  - Otherwise stay.
- HIGH_ACK: ready=1 for this cycle, then go to WRITE.
- WRITE: writeenable=1 for this cycle, with address and dataout stable. Then go to NEXT.
- NEXT:
  - address==WORDS-1: go to DONE, address held.
  - Otherwise address <= address+1, go to LOW_WAIT.
- DONE:
  - Terminal state: finish=1.
  - ready and writeenable stay at 0; datavalid is ignored.
  - address stays at WORDS-1; dataout holds the last word.
  - Only reset leaves DONE.
- Arithmetic: address increments by +1 and never wraps; it saturates at WORDS-1 through the DONE transition.
- Any state not listed above returns to LOW_WAIT.

## Timing

- Handshake:
  - A byte is captured on the first rising edge at which datavalid=1 and the FSM is in a WAIT state.
  - ready is high exactly one cycle: the cycle after capture.
  - The producer must change data or drop datavalid in the cycle after it sees ready=1.
- No double capture:
  - The ACK states never sample datain.
  - If datavalid is still 1 in the cycle after ready, the next WAIT state captures it as the next byte. That matches a producer that presents its next byte immediately.
- Latency:
  - Capture of the high byte to writeenable=1: 2 cycles (HIGH_ACK, then WRITE).
  - Minimum time per word: 6 cycles (LOW_WAIT, LOW_ACK, HIGH_WAIT, HIGH_ACK, WRITE, NEXT), with datavalid held at 1.
  - Minimum total load time: 6*WORDS cycles.
- writeenable is never high in the same cycle as ready.
- finish rises in the cycle after the final NEXT, which is 2 cycles after the last writeenable.
- Reset mid-operation:
  - reset=0 forces all outputs to their reset values immediately, asynchronously.
  - A partially assembled word is discarded.
  - After release, loading restarts at address 0, low byte first.
- Reset release: the FSM starts in LOW_WAIT and may capture on the first rising edge after reset deasserts.

## Test plan

- Reset: hold reset=0 and drive datavalid=1, datain=0xAA → ready=0, writeenable=0, finish=0, address=0, dataout=0x0000.
- Single word: send 0x34 then 0x12, each held until ready → exactly 2 ready pulses, then writeenable=1 for one cycle with address=0, dataout=0x1234. After NEXT, address=1.
- Back-to-back: hold datavalid=1 throughout, with datain changing to the next byte the cycle after each ready → one word every 6 cycles, no byte skipped or repeated.
- Full load with WORDS=4096 and word k = k: send low byte k[7:0], then high byte k[15:8] → 4096 writes with dataout == address at each write. Then finish=1 and address=4095.
- Boundary with WORDS=4: after the 4th write → finish=1, address=3. Further bytes produce no ready and no writeenable.
- Reset mid-word: send byte 0x55, pulse reset=0 during HIGH_WAIT, then send 0x11 and 0x22 → first write is address=0, dataout=0x2211.

Source files
------------

// File: rtl/title_loader_if.sv
// Byte-stream handshake and image-RAM write bus used by title_loader.
// Signals:
//   datain/datavalid : incoming byte and its valid flag (producer side)
//   ready            : one-cycle acknowledge that the byte was captured
//   address/dataout  : RAM write address and assembled 16-bit word
//   writeenable      : one-cycle RAM write strobe
//   finish           : image fully loaded, sticky until reset
// Modports: master = byte producer / RAM observer, slave = title_loader.
interface title_loader_if #(
  parameter int AW = 16
);
  logic [7:0]    datain;
  logic          datavalid;
  logic          ready;
  logic [AW-1:0] address;
  logic [15:0]   dataout;
  logic          writeenable;
  logic          finish;

  modport master (
    output datain, datavalid,
    input  ready, address, dataout, writeenable, finish
  );

  modport slave (
    input  datain, datavalid,
    output ready, address, dataout, writeenable, finish
  );
endinterface

// File: rtl/title_loader.sv
// title_loader: receives the title-screen image as a byte stream, packs
// byte pairs (low byte first) into 16-bit words and writes them to RAM
// addresses 0 .. WORDS-1, then raises finish until reset.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : title_loader_if.slave (byte handshake in, RAM write bus out)
module title_loader #(
  parameter int WORDS = 4096,
  parameter int AW    = 16
) (
  input  logic           clock,
  input  logic           reset,
  title_loader_if.slave  bus
);

  localparam logic [2:0] LOW_WAIT  = 3'd0;
  localparam logic [2:0] LOW_ACK   = 3'd1;
  localparam logic [2:0] HIGH_WAIT = 3'd2;
  localparam logic [2:0] HIGH_ACK  = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;
  localparam logic [2:0] NEXT      = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  logic [2:0]    state;
  logic [7:0]    low_byte;
  logic          ready_q;
  logic          we_q;
  logic          finish_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;

  // ready/writeenable are registered: they are set on the edge that enters
  // the ACK/WRITE state, so they are high exactly during that state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= LOW_WAIT;
      low_byte <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      finish_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      case (state)
        LOW_WAIT: begin
          if (bus.datavalid) begin
            low_byte <= bus.datain;
            ready_q  <= 1'b1;
            state    <= LOW_ACK;
          end
        end
        LOW_ACK: state <= HIGH_WAIT;
        HIGH_WAIT: begin
          if (bus.datavalid) begin
            data_q  <= {bus.datain, low_byte};
            ready_q <= 1'b1;
            state   <= HIGH_ACK;
          end
        end
        HIGH_ACK: begin
          we_q  <= 1'b1;
          state <= WRITE;
        end
        WRITE: state <= NEXT;
        NEXT: begin
          if (addr_q == LAST_ADDR) begin
            finish_q <= 1'b1;
            state    <= DONE;
          end else begin
            addr_q <= addr_q + AW'(1);
            state  <= LOW_WAIT;
          end
        end
        DONE: begin
          finish_q <= 1'b1;
          state    <= DONE;
        end
        default: state <= LOW_WAIT;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.writeenable = we_q;
  assign bus.finish      = finish_q;
  assign bus.address     = addr_q;
  assign bus.dataout     = data_q;

endmodule

// File: tb/tb_title_loader.sv
module tb_title_loader;

  localparam int WA = 4096;
  localparam int WB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  title_loader_if #(.AW(16)) bus_a ();
  title_loader_if #(.AW(16)) bus_b ();

  title_loader #(.WORDS(WA), .AW(16)) dut_a (.clock(clk), .reset(rst_a), .bus(bus_a.slave));
  title_loader #(.WORDS(WB), .AW(16)) dut_b (.clock(clk), .reset(rst_b), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  logic        rdy  [2];
  logic        we   [2];
  logic        fin  [2];
  logic [15:0] addr [2];
  logic [15:0] dout [2];

  assign rdy[0]  = bus_a.ready;       assign rdy[1]  = bus_b.ready;
  assign we[0]   = bus_a.writeenable; assign we[1]   = bus_b.writeenable;
  assign fin[0]  = bus_a.finish;      assign fin[1]  = bus_b.finish;
  assign addr[0] = bus_a.address;     assign addr[1] = bus_b.address;
  assign dout[0] = bus_a.dataout;     assign dout[1] = bus_b.dataout;

  // Output monitor: counts pulses and flags protocol violations.
  int   cyc = 0;
  int   ready_cnt [2] = '{0, 0};
  int   we_cnt    [2] = '{0, 0};
  int   overlap   [2] = '{0, 0};
  int   long_rdy  [2] = '{0, 0};
  int   long_we   [2] = '{0, 0};
  int   we_cyc    [2] = '{0, 0};
  int   prev_we   [2] = '{0, 0};
  logic prev_rdy  [2] = '{1'b0, 1'b0};
  logic prev_wen  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] === 1'b1) ready_cnt[i] = ready_cnt[i] + 1;
      if (rdy[i] === 1'b1 && prev_rdy[i] === 1'b1) long_rdy[i] = long_rdy[i] + 1;
      if (we[i] === 1'b1 && prev_wen[i] === 1'b1) long_we[i] = long_we[i] + 1;
      if (we[i] === 1'b1) begin
        we_cnt[i]  = we_cnt[i] + 1;
        prev_we[i] = we_cyc[i];
        we_cyc[i]  = cyc;
      end
      if (rdy[i] === 1'b1 && we[i] === 1'b1) overlap[i] = overlap[i] + 1;
      prev_rdy[i] = rdy[i];
      prev_wen[i] = we[i];
    end
  end

  // Reference model: number of words committed since reset per DUT; the
  // next write must go to that address, and finish follows count == WORDS.
  int exp_count [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample point well away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      bus_a.datavalid = v; bus_a.datain = d;
    end else begin
      bus_b.datavalid = v; bus_b.datain = d;
    end
  endtask

  // Present one byte, hold until ready is seen, then release it in the
  // cycle after ready unless the caller will present the next byte.
  task automatic send_byte(input int sel, input logic [7:0] b, input bit keep, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      drive(sel, 1'b0, 8'($urandom));
      tick();
    end
    drive(sel, 1'b1, b);
    n = 0;
    do begin
      tick();
      n++;
    end while (rdy[sel] !== 1'b1 && n < 40);
    check("ready_seen", 32'(rdy[sel]), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) drive(sel, 1'b0, 8'($urandom));
  endtask

  task automatic expect_write(input int sel, input logic [15:0] data, input bit chk_period);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (we[sel] !== 1'b1 && n < 20);
    check("we_seen", 32'(we[sel]), 32'd1);
    check("wr_addr", 32'(addr[sel]), 32'(exp_count[sel]));
    check("wr_data", 32'(dout[sel]), 32'(data));
    if (chk_period) check("word_period", 32'(we_cyc[sel] - prev_we[sel]), 32'd6);
    exp_count[sel]++;
  endtask

  task automatic send_word(input int sel, input logic [15:0] w, input bit b2b, input bit chk_period);
    send_byte(sel, w[7:0], b2b, b2b ? 0 : int'($urandom_range(0, 3)));
    send_byte(sel, w[15:8], b2b, b2b ? 0 : int'($urandom_range(0, 3)));
    expect_write(sel, w, chk_period);
  endtask

  task automatic check_reset_vals(input int sel);
    check("rst_ready",  32'(rdy[sel]),  32'd0);
    check("rst_we",     32'(we[sel]),   32'd0);
    check("rst_finish", 32'(fin[sel]),  32'd0);
    check("rst_addr",   32'(addr[sel]), 32'd0);
    check("rst_dout",   32'(dout[sel]), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] last_b;
    int r0, w0;

    // Reset held with an active producer.
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 1'b1, 8'hAA); drive(1, 1'b1, 8'hAA);
    repeat (3) tick();
    check_reset_vals(0);
    check_reset_vals(1);
    drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00);
    rst_a = 1'b1; rst_b = 1'b1;
    tick();

    // Single word 0x1234 on DUT A.
    r0 = ready_cnt[0];
    send_word(0, 16'h1234, 1'b0, 1'b0);
    check("single_ready_pulses", 32'(ready_cnt[0] - r0), 32'd2);
    tick(); tick();
    check("addr_after_next", 32'(addr[0]), 32'(exp_count[0]));

    // Reset during HIGH_WAIT discards the half word.
    send_byte(0, 8'h55, 1'b0, 1);
    rst_a = 1'b0;
    #1;
    check("async_rst_addr",  32'(addr[0]), 32'd0);
    check("async_rst_dout",  32'(dout[0]), 32'd0);
    check("async_rst_ready", 32'(rdy[0]),  32'd0);
    check("async_rst_we",    32'(we[0]),   32'd0);
    tick(); tick();
    rst_a = 1'b1;
    exp_count[0] = 0;
    tick();
    send_word(0, 16'h2211, 1'b0, 1'b0);

    // Back-to-back random words, datavalid held high throughout.
    for (int k = 0; k < 8; k++) begin
      w = 16'($urandom);
      send_word(0, w, 1'b1, k != 0);
    end
    drive(0, 1'b0, 8'h00);
    repeat (3) tick();

    // Full load of DUT A: word k = k.
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    exp_count[0] = 0;
    r0 = ready_cnt[0];
    w0 = we_cnt[0];
    for (int k = 0; k < WA; k++) begin
      send_word(0, 16'(k), 1'b1, k != 0);
    end
    tick();
    check("a_finish_in_next", 32'(fin[0]), 32'd0);
    tick();
    check("a_finish",        32'(fin[0]),  32'(exp_count[0] == WA));
    check("a_final_addr",    32'(addr[0]), 32'(WA - 1));
    check("a_total_writes",  32'(we_cnt[0] - w0), 32'(WA));
    check("a_total_readies", 32'(ready_cnt[0] - r0), 32'(2 * WA));
    drive(0, 1'b0, 8'h00);

    // Boundary: DUT B with WORDS=4.
    last_b = '0;
    for (int k = 0; k < WB; k++) begin
      last_b = 16'($urandom);
      send_word(1, last_b, 1'b0, 1'b0);
    end
    tick();
    check("b_finish_in_next", 32'(fin[1]), 32'd0);
    tick();
    check("b_finish",     32'(fin[1]),  32'(exp_count[1] == WB));
    check("b_final_addr", 32'(addr[1]), 32'(WB - 1));
    r0 = ready_cnt[1];
    w0 = we_cnt[1];
    for (int k = 0; k < 20; k++) begin
      drive(1, 1'b1, 8'($urandom));
      tick();
    end
    drive(1, 1'b0, 8'h00);
    check("done_no_ready",  32'(ready_cnt[1] - r0), 32'd0);
    check("done_no_write",  32'(we_cnt[1] - w0), 32'd0);
    check("done_finish",    32'(fin[1]),  32'd1);
    check("done_addr",      32'(addr[1]), 32'(WB - 1));
    check("done_dout_held", 32'(dout[1]), 32'(last_b));

    // Protocol invariants over the whole run.
    for (int i = 0; i < 2; i++) begin
      check("ready_we_overlap", 32'(overlap[i]),  32'd0);
      check("ready_multi_cycle", 32'(long_rdy[i]), 32'd0);
      check("we_multi_cycle",    32'(long_we[i]),  32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
